// File: rtl/cache_pkg.sv
// cache_pkg: shared sizing, FSM state encoding and saturating-counter helper for the cache.
package cache_pkg;
    localparam int NUM_LINES_DEFAULT = 16;
    localparam int INDEX_W = $clog2(NUM_LINES_DEFAULT);
    localparam int TAG_W = 32 - INDEX_W;
    typedef enum logic [1:0] {IDLE, LOOKUP, FETCH, WRITE} state_t;
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/cache_line_array.sv
// cache_line_array: direct-mapped valid/tag/data store, one write port, combinational read.
module cache_line_array
    import cache_pkg::*;
#(
    parameter int NUM_LINES = NUM_LINES_DEFAULT,
    parameter int IW = $clog2(NUM_LINES),
    parameter int TW = 32 - IW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [IW-1:0] index,
    input  logic [TW-1:0] wtag,
    input  logic [31:0]   wdata,
    output logic          rvalid,
    output logic [TW-1:0] rtag,
    output logic [31:0]   rdata
);
    logic [NUM_LINES-1:0] valid;
    logic [TW-1:0]        tags [NUM_LINES];
    logic [31:0]          data [NUM_LINES];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) valid <= '0;
        else if (we) valid[index] <= 1'b1;
    end
    // tag/data need no reset: valid gates every use
    always_ff @(posedge clk) begin
        if (we) begin
            tags[index] <= wtag;
            data[index] <= wdata;
        end
    end
    assign rvalid = valid[index];
    assign rtag   = tags[index];
    assign rdata  = data[index];
endmodule

// File: rtl/cache_controller.sv
// cache_controller: write-through, no-write-allocate direct-mapped cache with hit/miss statistics.
module cache_controller
    import cache_pkg::*;
#(
    parameter int NUM_LINES = NUM_LINES_DEFAULT,
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        hit,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr_en,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = 32 - IW;
    localparam int CW = $clog2(MEM_LAT + 1);
    state_t        state, state_d;
    logic [CW-1:0] cnt;
    logic          we_q;
    logic [31:0]   addr_q, wdata_q;
    logic          line_valid, line_hit, line_we, fetch_last;
    logic [TW-1:0] line_tag;
    logic [31:0]   line_data, line_wdata;
    cache_line_array #(.NUM_LINES(NUM_LINES)) u_lines (
        .clk   (clk),
        .reset (reset),
        .we    (line_we),
        .index (addr_q[IW-1:0]),
        .wtag  (addr_q[31:IW]),
        .wdata (line_wdata),
        .rvalid(line_valid),
        .rtag  (line_tag),
        .rdata (line_data)
    );
    assign line_hit   = line_valid && (line_tag == addr_q[31:IW]);
    assign fetch_last = cnt == CW'(MEM_LAT - 1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_d;
            cnt   <= (state == FETCH) ? cnt + CW'(1) : '0;
            if (state == IDLE && cpu_req) begin
                we_q    <= cpu_we;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP) begin
            if (line_hit) hit_count <= sat_inc(hit_count);
            else miss_count <= sat_inc(miss_count);
        end
    end
    // WRITE re-evaluates line_hit: the line cannot change between LOOKUP and WRITE
    always_comb begin
        state_d    = state;
        cpu_ready  = 1'b0;
        cpu_rdata  = '0;
        hit        = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        line_we    = 1'b0;
        line_wdata = '0;
        case (state)
            IDLE: state_d = cpu_req ? LOOKUP : IDLE;
            LOOKUP: begin
                state_d   = we_q ? WRITE : (line_hit ? IDLE : FETCH);
                cpu_ready = !we_q && line_hit;
                hit       = cpu_ready;
                cpu_rdata = cpu_ready ? line_data : '0;
            end
            FETCH: begin
                mem_rd_en  = 1'b1;
                mem_addr   = addr_q;
                line_we    = fetch_last;
                line_wdata = fetch_last ? mem_rdata : '0;
                cpu_ready  = fetch_last;
                cpu_rdata  = fetch_last ? mem_rdata : '0;
                state_d    = fetch_last ? IDLE : FETCH;
            end
            WRITE: begin
                mem_wr_en  = 1'b1;
                mem_addr   = addr_q;
                mem_wdata  = wdata_q;
                line_we    = line_hit;
                line_wdata = wdata_q;
                cpu_ready  = 1'b1;
                hit        = line_hit;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
